mdu_iter: RTL

- Parametrised iterative multiply/divide unit for the execute stage; successor to the fixed-IP HI/LO path.
- Implements MULT, MULTU, DIV and DIVU over a configurable WIDTH using a shared radix-2 datapath: shift-add for multiply, restoring division for divide.
- Exposes a start/busy/valid handshake that drives the pipeline stall, plus a flush input so exceptions abort an operation in progress.

---
 rtl/mdu_iter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit for the execute stage.
//
// Operations (op): 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. One radix-2 step runs per cycle.
// Multiply uses shift-add into a 2*WIDTH accumulator. Divide uses restoring division, with
// the remainder and quotient sharing that same accumulator. Signed operations run on
// magnitudes. The FIX state restores the result signs.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   flush        synchronous abort of an operation in flight (valid is not raised)
//   start        request, accepted only while busy=0; op/a/b are sampled with it
//   op, a, b     operation select, rs operand, rt operand
//   busy         operation in flight (CALC/FIX); drives the pipeline stall
//   valid        one-cycle pulse; hi/lo/div_by_zero change only in that cycle
//   hi, lo       product high/low half, or remainder/quotient
//   div_by_zero  last completed op was a divide by zero
//
// Optional build macro MDU_EARLY_OUT_EN lets multiplies leave CALC once the remaining
// multiplier bits are all zero. Results are identical either way.

module mdu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Multiply: running product. Divide: {partial remainder, dividend/quotient}.
  logic [W2-1:0]    acc_q, acc_d;
  // Multiply: multiplicand shifted left each step. Divide: divisor in the low half.
  logic [W2-1:0]    mcand_q, mcand_d;
  // Multiplier magnitude, consumed LSB first.
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;          // product/quotient must be negated
  logic             rem_neg_q, rem_neg_d;  // remainder takes the sign of a
  logic             dbz_pend_q, dbz_pend_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  // Operand conditioning at accept time.
  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Divider step.
  logic [WIDTH:0]   div_shift;  // partial remainder shifted left with next dividend bit
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] div_rem;

  // Step control and sign fix-up.
  logic             last_step;
  logic             early_out;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  always_comb begin
    div_shift = acc_q[W2-1:WIDTH-1];
    div_ge    = (div_shift >= {1'b0, mcand_q[WIDTH-1:0]});
    // When div_ge holds the difference is below the divisor, so WIDTH bits suffice.
    div_sub   = div_shift[WIDTH-1:0] - mcand_q[WIDTH-1:0];
    div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
  end

  always_comb begin
`ifdef MDU_EARLY_OUT_EN
    early_out = ~is_div_q & (mplier_q[WIDTH-1:1] == '0);
`else
    early_out = 1'b0;
`endif
    last_step = (cnt_q == CNT_W'(WIDTH - 1)) | early_out;
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    dbz_pend_d = dbz_pend_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;

    if (flush) begin
      // Abort; results already committed in DONE are unaffected.
      state_d = StIdle;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          state_d = StIdle;
          busy_d  = 1'b0;
          if (start) begin
            state_d    = StCalc;
            busy_d     = 1'b1;
            cnt_d      = '0;
            a_raw_d    = a;
            is_div_d   = op[1];
            neg_d      = a_neg ^ b_neg;
            rem_neg_d  = a_neg;
            dbz_pend_d = op[1] & (b == '0);
            mplier_d   = b_mag;
            mcand_d    = {{WIDTH{1'b0}}, op[1] ? b_mag : a_mag};
            acc_d      = op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
          end
        end
        StCalc: begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end
          if (last_step) begin
            state_d = StFix;
          end
        end
        StFix: begin
          state_d = StDone;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          dbz_d   = is_div_q & dbz_pend_q;
          if (!is_div_q) begin
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (dbz_pend_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      dbz_pend_q <= dbz_pend_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign valid       = valid_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
